poly_cyclic_reducer: RTL

- Downstream consumer of the GF(2) Toom-k polynomial multiplier (`CompleteMultiplier`, N = 17669).
- Captures the multiplier's full 2N-bit product when done is asserted and folds it modulo x^N − 1, i.e. reduces it into the cyclic ring GF(2)[x]/(x^N − 1).
- Streams the N-bit result out as W-bit words over a valid/ready interface to the next stage (encoder / memory writer).

---
 rtl/poly_cfg_pkg.sv | 21 ++
 rtl/poly_cyclic_reducer_cyclic_fold.sv | 19 +
 rtl/poly_cyclic_reducer.sv | 95 +++++++++
 3 files changed

// File: rtl/poly_cfg_pkg.sv
// Shared configuration for the Toom-k multiplier slice.
// Ring size, output framing and the reducer state encoding.
package poly_cfg_pkg;

   localparam int N      = 17669;
   localparam int W      = 64;
   localparam int NW     = (N + W - 1) / W;
   localparam int LB     = N - (NW - 1) * W;
   localparam int PROD_W = 2 * N;
   localparam int IDX_W  = 9;
   localparam int WL     = $clog2(W);
   localparam int PAD_W  = NW * W;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

endpackage

// File: rtl/poly_cyclic_reducer_cyclic_fold.sv
// Combinational fold of a 2N-bit product modulo x^N - 1.
// Coefficient k sits at product bit k+1; bit 0 is a format flag.
module cyclic_fold
   import poly_cfg_pkg::*;
(
   input  logic [PROD_W-1:0] prod,
   output logic [N-1:0]      r,
   output logic              lsb
);

   // x^(k+N) aliases to x^k; the top coefficient has no high partner
   always_comb begin
      r          = '0;
      r[N-2:0]   = prod[N-1:1] ^ prod[PROD_W-1:N+1];
      r[N-1]     = prod[N];
      lsb        = prod[0];
   end

endmodule

// File: rtl/poly_cyclic_reducer.sv
// Captures the multiplier product, folds it into GF(2)[x]/(x^N-1)
// and streams the N-bit result as W-bit words.
module poly_cyclic_reducer
   import poly_cfg_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [PROD_W-1:0] in_prod,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      out_data,
   output logic              out_last,
   output logic [IDX_W-1:0]  out_idx,
   output logic              fmt_err
);

   state_t             state;
   state_t             state_nxt;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   idx_nxt;
   logic               cap;
   logic [N-1:0]       r;
   logic [N-1:0]       fold;
   logic               fold_lsb;
   logic [PAD_W-1:0]   r_pad;
   logic [IDX_W+WL-1:0] off;

   cyclic_fold u_fold (
      .prod (in_prod),
      .r    (fold),
      .lsb  (fold_lsb)
   );

   // control state, word index and the format-error pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         idx     <= '0;
         fmt_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         fmt_err <= cap & fold_lsb;
      end
   end

   // result register loads only on an accepted product
   always_ff @(posedge clk) begin
      if (cap) begin
         r <= fold;
      end
   end

   // next-state, handshakes and the word mux
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cap       = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_data  = '0;
      out_idx   = idx;
      r_pad     = {{(PAD_W - N){1'b0}}, r};
      off       = {idx, {WL{1'b0}}};
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               cap       = 1'b1;
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            out_valid = 1'b1;
            out_last  = (idx == LAST_IDX);
            out_data  = r_pad[off +: W];
            if (out_ready) begin
               if (idx == LAST_IDX) begin
                  idx_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
